seq_mult_core: RTL and testbench
================================

Name: seq_mult_core

Overview:
- Radix-2 shift-add sequential multiplier core of the Sequential Multiplier.
- Sits directly upstream of the binary-to-complement-2 output converter.
- Takes unsigned operand magnitudes plus their sign bits, iterates one partial product per clock, and presents a DW-bit magnitude and result sign. The converter turns that pair into the final complement-2 product.
- Also flags results not representable in DW-bit complement 2.

Parameters:
DW, DW_MDR (from mdr_pkg), operand and result data width in bits; minimum 4.
CW, $clog2(DW)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
mag_a  input  DW  multiplicand magnitude, unsigned.
mag_b  input  DW  multiplier magnitude, unsigned.
sign_a  input  1  sign of operand A (1 = negative).
sign_b  input  1  sign of operand B.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  single-cycle pulse when the result is valid.
product  output  DW  result magnitude; feeds the converter's binary input.
sign  output  1  result sign; feeds the converter's sign input.
overflow  output  1  result not representable in DW-bit complement 2.

Behaviour:
- Reset (rst low, asynchronous): state to IDLE. busy, done, product, sign, overflow, counter, accumulator and operand registers all go to 0.
- FSM states:
  - IDLE → RUN when start=1. On that edge, capture mag_a and mag_b, capture sign_a^sign_b, clear the 2*DW accumulator, and clear the counter.
  - RUN, each cycle: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator. Then shift the multiplicand left 1 and the multiplier right 1, and increment the counter. After exactly DW RUN cycles, go to DONE.
  - DONE: one cycle. Register product, sign and overflow; done=1 for this cycle only; then go to IDLE.
- Latency: done is high exactly DW+1 cycles after the edge that sampled start. There is no early termination; latency is fixed regardless of operand values.
- busy is 1 in RUN and DONE, 0 in IDLE.
- start is ignored while busy. Back-to-back operation: start may be high in the IDLE cycle right after DONE and is accepted then.
- Operand inputs are don't-care except on the accepting edge. They may change freely during RUN.
- Arithmetic: the accumulator is 2*DW bits and never wraps. product = accumulator[DW-1:0].
- sign = captured sign XOR, forced to 0 when the full 2*DW accumulator is 0 (no negative zero).
- overflow = 1 if any of these hold:
  - accumulator[2*DW-1:DW] is nonzero;
  - sign=0 and accumulator[DW-1]=1;
  - sign=1 and accumulator[DW-1:0] > 2^(DW-1).
- Magnitude exactly 2^(DW-1) with sign=1 is legal: overflow=0. The downstream converter yields the most negative value.
- product, sign and overflow hold their values until the next DONE; they are not cleared on the next start.
- Reset asserted mid-RUN aborts immediately. No done pulse follows release; the next start after release behaves as after power-up.
- Zero operands: the full DW cycles still run; product=0, sign=0, overflow=0.

Test Plan:
- DW=8, mag_a=5, mag_b=3, signs 0/0, start 1 cycle → done exactly 9 cycles later; product=15, sign=0, overflow=0; busy high for 9 cycles.
- mag_a=16, mag_b=8, sign_a=1, sign_b=0 → product=128, sign=1, overflow=0. Same magnitudes with both signs 0 → product=128, sign=0, overflow=1.
- mag_a=255, mag_b=255 → product=0x01, overflow=1 (upper half 0xFE).
- mag_a=0, mag_b=200, sign_a=1 → product=0, sign=0, overflow=0, still 9-cycle latency.
- start held high continuously with new operands (7,6), then (2,9) → results 42 then 18. Start pulses during busy are ignored; the second operation is accepted the cycle after done.
- Reset pulsed low in RUN cycle 4 → busy, done and outputs go to 0 asynchronously; no done pulse appears. After release, start with (12,12) → product=144 and overflow=1 (sign 0) after 9 cycles.

Source files
------------

// File: rtl/seq_mult_core.sv
// Radix-2 shift-add sequential multiplier: one partial product per clock,
// magnitude/sign result plus complement-2 representability flag.
package mdr_pkg;
    localparam int DW_MDR = 8;
endpackage

module seq_mult_core
    import mdr_pkg::*;
#(
    parameter int DW = DW_MDR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] mag_a,
    input  logic [DW-1:0] mag_b,
    input  logic          sign_a,
    input  logic          sign_b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product,
    output logic          sign,
    output logic          overflow
);

    localparam int CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);
    localparam logic [DW-1:0] MINMAG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t nxt;

    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            sgn_r;

    logic            res_sign;
    logic            res_ovf;
    logic [DW-1:0]   lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (cnt == LAST) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // No negative zero; a magnitude of exactly 2^(DW-1) is legal when negative.
    always_comb begin
        lo       = acc[DW-1:0];
        res_sign = sgn_r & (|acc);
        res_ovf  = (|acc[2*DW-1:DW])
                 | (~res_sign & lo[DW-1])
                 | (res_sign & (lo > MINMAG));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            sgn_r    <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                mcand  <= {{DW{1'b0}}, mag_a};
                mplier <= mag_b;
                sgn_r  <= sign_a ^ sign_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end else if (state == DONE) begin
                done     <= 1'b1;
                product  <= lo;
                sign     <= res_sign;
                overflow <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core: directed plan cases plus random
// operands against an integer-arithmetic reference.
module tb_seq_mult_core;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] mag_a;
    logic [DW-1:0] mag_b;
    logic          sign_a;
    logic          sign_b;
    logic          busy;
    logic          done;
    logic [DW-1:0] product;
    logic          sign;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    seq_mult_core #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .sign_a   (sign_a),
        .sign_b   (sign_b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .sign     (sign),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic op(input int a, input int b, input bit sa, input bit sb,
                      input bit hold, input string tag);
        int full;
        int v;
        int lat;
        int bcnt;
        bit es;
        bit eo;
        full = a * b;
        es = (sa ^ sb) && (full != 0);
        v = es ? -full : full;
        eo = (v > 2 ** (DW - 1) - 1) || (v < -(2 ** (DW - 1)));
        mag_a = DW'(a);
        mag_b = DW'(b);
        sign_a = sa;
        sign_b = sb;
        start = 1'b1;
        @(posedge clk);
        #1;
        mag_a = DW'($urandom);
        mag_b = DW'($urandom);
        sign_a = 1'($urandom);
        sign_b = 1'($urandom);
        lat = -1;
        bcnt = 0;
        for (int k = 0; k <= 20; k++) begin
            if (!hold) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
        if (!hold) start = 1'b0;
        chk({tag, "_latency"}, lat, DW + 1);
        if (lat < 0) return;
        chk({tag, "_busy_cycles"}, bcnt, DW + 1);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        chk({tag, "_product"}, int'(product), full % (2 ** DW));
        chk({tag, "_sign"}, int'(sign), int'(es));
        chk({tag, "_overflow"}, int'(overflow), int'(eo));
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        start = 1'b0;
        mag_a = '0;
        mag_b = '0;
        sign_a = 1'b0;
        sign_b = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_product", int'(product), 0);
        chk("rst_sign", int'(sign), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        op(5, 3, 0, 0, 0, "p5x3");
        @(negedge clk);
        chk("done_single_pulse", int'(done), 0);
        chk("product_held", int'(product), 15);

        op(16, 8, 1, 0, 0, "neg128");
        op(16, 8, 0, 0, 0, "pos128");
        op(255, 255, 0, 0, 0, "max");
        op(0, 200, 1, 0, 0, "zero");
        op(7, 6, 0, 0, 1, "b2b1");
        op(2, 9, 0, 0, 0, "b2b2");
        op(11, 12, 1, 1, 0, "negneg");
        op(129, 1, 1, 0, 0, "neg129");

        for (int i = 0; i < 20; i++)
            op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               1'($urandom), 1'($urandom), 1'($urandom), "rand");

        // Abort mid-run with asynchronous reset.
        @(negedge clk);
        mag_a = 8'd100;
        mag_b = 8'd100;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_product", int'(product), 0);
        chk("abort_sign", int'(sign), 0);
        chk("abort_overflow", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        op(12, 12, 0, 0, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
